// File: rtl/preproc_pkg.sv
// Shared preprocessing constants and the block feeder state encoding.
package preproc_pkg;

    localparam int DW    = 12;
    localparam int N     = 8;
    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        LAST_WR = 2'd1,
        DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/block_feeder_if.sv
// Serial sample stream (valid/ready) feeding the block feeder.
interface block_feeder_if #(
    parameter int DW = preproc_pkg::DW
);
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/block_feeder.sv
// Packs a raster 8x8 block of serial samples into rows for a transpose buffer,
// then drains it by issuing eight column reads before accepting the next block.
module block_feeder #(
    parameter int DW = preproc_pkg::DW,
    parameter int N  = preproc_pkg::N
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic [DW-1:0] o_data0,
    output logic [DW-1:0] o_data1,
    output logic [DW-1:0] o_data2,
    output logic [DW-1:0] o_data3,
    output logic [DW-1:0] o_data4,
    output logic [DW-1:0] o_data5,
    output logic [DW-1:0] o_data6,
    output logic [DW-1:0] o_data7,
    output logic          o_write,
    output logic          o_read,
    output logic          o_block_done
);
    import preproc_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] drn_q, drn_d;
    logic             write_q, write_d;
    logic [DW-1:0]    lane_q [N];
    logic [DW-1:0]    lane_d [N];
    logic [DW-1:0]    data_q [N];
    logic [DW-1:0]    data_d [N];
    logic             accept;

    assign o_ready = (state_q == FILL);
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drn_d   = drn_q;
        write_d = 1'b0;
        lane_d  = lane_q;
        data_d  = data_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    lane_d[col_q] = i_data;
                    col_d         = col_q + 1'b1;
                    // Last sample of a row bypasses the lane array so the row
                    // is presented on the very next cycle.
                    if (col_q == LAST) begin
                        for (int k = 0; k < N - 1; k++) data_d[k] = lane_q[k];
                        data_d[N-1] = i_data;
                        write_d     = 1'b1;
                        if (row_q == LAST) begin
                            row_d   = '0;
                            state_d = LAST_WR;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
            end
            LAST_WR: state_d = DRAIN;
            DRAIN: begin
                drn_d = drn_q + 1'b1;
                if (drn_q == LAST) begin
                    drn_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            drn_q   <= '0;
            write_q <= 1'b0;
            for (int k = 0; k < N; k++) data_q[k] <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drn_q   <= drn_d;
            write_q <= write_d;
            data_q  <= data_d;
        end
    end

    // Pack lanes need no reset: col_q restarts at lane 0, so stale contents
    // are always overwritten before they can reach a row.
    always_ff @(posedge i_clk) begin
        lane_q <= lane_d;
    end

    assign o_write      = write_q;
    assign o_read       = (state_q == DRAIN);
    assign o_block_done = (state_q == DRAIN) && (drn_q == LAST);

    assign o_data0 = data_q[0];
    assign o_data1 = data_q[1];
    assign o_data2 = data_q[2];
    assign o_data3 = data_q[3];
    assign o_data4 = data_q[4];
    assign o_data5 = data_q[5];
    assign o_data6 = data_q[6];
    assign o_data7 = data_q[7];

endmodule

// File: tb/tb_block_feeder.sv
// Directed bench for block_feeder: row and column scoreboards filled from the
// stimulus, with a behavioural transpose buffer on the DUT outputs.
module tb_block_feeder;

    localparam int W = 12;
    localparam int L = 8;
    typedef logic [L*W-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    block_feeder_if #(.DW(W)) bif ();

    logic [W-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic         wr, rd, done;

    block_feeder #(.DW(W), .N(L)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (bif.valid),
        .i_data       (bif.data),
        .o_ready      (bif.ready),
        .o_data0      (d0),
        .o_data1      (d1),
        .o_data2      (d2),
        .o_data3      (d3),
        .o_data4      (d4),
        .o_data5      (d5),
        .o_data6      (d6),
        .o_data7      (d7),
        .o_write      (wr),
        .o_read       (rd),
        .o_block_done (done)
    );

    vec_t         rowq[$];
    vec_t         colq[$];
    vec_t         mrow;
    int           mcol, mcnt;
    logic [W-1:0] bs [64];
    vec_t         tmem [L];
    int           wp, rp, rd_in_blk, lowrun;
    int           wr_cnt, rd_cnt, done_cnt;
    bit           mon_en;
    int           checks, passes, fails;

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic record(input logic [W-1:0] d);
        vec_t c;
        mrow[mcol*W +: W] = d;
        mcol++;
        if (mcol == L) begin
            rowq.push_back(mrow);
            mcol = 0;
        end
        bs[mcnt] = d;
        mcnt++;
        if (mcnt == 64) begin
            for (int k = 0; k < L; k++) begin
                for (int j = 0; j < L; j++) c[j*W +: W] = bs[j*L + k];
                colq.push_back(c);
            end
            mcnt = 0;
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        int t = 0;
        @(negedge clk);
        bif.valid = 1'b1;
        bif.data  = d;
        while (!bif.ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", vec_t'(t), vec_t'(0));
        else record(d);
    endtask

    task automatic idle();
        @(negedge clk);
        bif.valid = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst       = 1'b1;
        bif.valid = 1'b1;
        bif.data  = 12'hBAD;
        @(negedge clk);
        rst       = 1'b0;
        bif.valid = 1'b0;
        mcol = 0; mcnt = 0;
        rowq.delete(); colq.delete();
        wp = 0; rp = 0; rd_in_blk = 0; lowrun = 0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", vec_t'(done_cnt >= target), vec_t'(1));
    endtask

    // Outputs are observed mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        vec_t act, col;
        if (mon_en && !rst) begin
            act = {d7, d6, d5, d4, d3, d2, d1, d0};
            if (wr || rd) chk("wr_rd_exclusive", vec_t'(wr && rd), vec_t'(0));
            if (wr) begin
                wr_cnt++;
                if (rowq.size() == 0) chk("row_queue_empty", vec_t'(rowq.size()), vec_t'(1));
                else chk("row", act, rowq.pop_front());
                tmem[wp] = act;
                wp = (wp + 1) % L;
            end
            if (rd || done) chk("block_done", vec_t'(done), vec_t'(rd && rd_in_blk == L - 1));
            if (rd) begin
                rd_cnt++;
                for (int j = 0; j < L; j++) col[j*W +: W] = tmem[j][rp*W +: W];
                if (colq.size() == 0) chk("col_queue_empty", vec_t'(colq.size()), vec_t'(1));
                else chk("column", col, colq.pop_front());
                rp = (rp + 1) % L;
                rd_in_blk = (rd_in_blk + 1) % L;
            end
            if (done) done_cnt++;
            if (!bif.ready) lowrun++;
            else if (lowrun > 0) begin
                chk("ready_low_run", vec_t'(lowrun), vec_t'(9));
                lowrun = 0;
            end
        end
    end

    initial begin
        int wc, rc, dc, t;
        checks = 0; passes = 0; fails = 0;
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
        mcol = 0; mcnt = 0; wp = 0; rp = 0; rd_in_blk = 0; lowrun = 0;
        mon_en = 1'b0;
        rst = 1'b1; bif.valid = 1'b0; bif.data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_ready", vec_t'(bif.ready), vec_t'(1));
        chk("rst_write", vec_t'(wr), vec_t'(0));
        chk("rst_read", vec_t'(rd), vec_t'(0));
        chk("rst_done", vec_t'(done), vec_t'(0));
        chk("rst_data", {d7, d6, d5, d4, d3, d2, d1, d0}, vec_t'(0));

        // First row: write strobe exactly one cycle after the 8th accept.
        for (int i = 1; i <= 8; i++) send(W'(i));
        idle();
        chk("wr_latency", vec_t'(wr), vec_t'(1));
        idle();
        chk("wr_one_cycle", vec_t'(wr), vec_t'(0));

        // Continuous block, then i_valid held with 0xFFF through the drain.
        pulse_rst();
        wc = wr_cnt; rc = rd_cnt; dc = done_cnt;
        for (int i = 0; i < 64; i++) send(W'(i));
        @(negedge clk);
        bif.valid = 1'b1;
        bif.data  = 12'hFFF;
        t = 0;
        while (!bif.ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_low_cycles", vec_t'(t), vec_t'(9));
        chk("blk1_writes", vec_t'(wr_cnt - wc), vec_t'(8));
        chk("blk1_reads", vec_t'(rd_cnt - rc), vec_t'(8));
        chk("blk1_done", vec_t'(done_cnt - dc), vec_t'(1));

        // Toggling valid, same samples; first one replaces 0xFFF in lane 0.
        wc = wr_cnt; dc = done_cnt;
        bif.data = W'(0);
        record(W'(0));
        for (int i = 1; i < 64; i++) begin
            idle();
            send(W'(i));
        end
        idle();
        wait_done(dc + 1);
        chk("blk2_writes", vec_t'(wr_cnt - wc), vec_t'(8));

        // Reset in the middle of a block discards the partial row.
        for (int i = 0; i < 13; i++) send(W'(12'h300 + i));
        idle();
        pulse_rst();
        chk("midrst_data", {d7, d6, d5, d4, d3, d2, d1, d0}, vec_t'(0));
        chk("midrst_write", vec_t'(wr), vec_t'(0));
        chk("midrst_ready", vec_t'(bif.ready), vec_t'(1));
        wc = wr_cnt;
        for (int i = 0; i < 8; i++) send(W'(12'hA00 + i));
        idle();
        idle();
        chk("midrst_writes", vec_t'(wr_cnt - wc), vec_t'(1));

        // Back-to-back random blocks through the transpose buffer.
        pulse_rst();
        dc = done_cnt;
        for (int i = 0; i < 128; i++) send(W'($urandom_range(0, 4095)));
        idle();
        wait_done(dc + 2);
        chk("b2b_rows_left", vec_t'(rowq.size()), vec_t'(0));
        chk("b2b_cols_left", vec_t'(colq.size()), vec_t'(0));

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
